// File: rtl/seq_divider.sv
// Iterative signed restoring divider: one quotient bit per enabled cycle, MSB first.
// Latency: done pulses WIDTH+2 enabled edges after the accepting edge (2 edges for a zero divisor).
// Backpressure: start is ignored while busy; enable=0 freezes all state and outputs.
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             start,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PREP,
        S_DIVIDE,
        S_FIX
    } state_t;

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_a;        // latched dividend
    logic [WIDTH-1:0] r_b;        // latched divisor
    logic             r_sign_q;
    logic             r_sign_r;
    logic [WIDTH-1:0] r_dvd;      // dividend magnitude, shifts out MSB first while quotient bits shift in
    logic [WIDTH-1:0] r_dvs;      // divisor magnitude
    logic [WIDTH-1:0] r_rem;      // partial remainder; always < divisor so WIDTH bits hold it
    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_remo;
    logic             r_busy;
    logic             r_done;
    logic             r_dbz;

    logic [WIDTH-1:0] w_mag_a;
    logic [WIDTH-1:0] w_mag_b;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_trial;
    logic             w_qbit;

    // Magnitudes of the latched operands; |minInt| comes out as 2^(WIDTH-1), which fits unsigned.
    assign w_mag_a = r_a[WIDTH-1] ? (~r_a + 1'b1) : r_a;
    assign w_mag_b = r_b[WIDTH-1] ? (~r_b + 1'b1) : r_b;

    // Shift in the next dividend bit and trial-subtract; the extra top bit is the borrow.
    assign w_shift = {r_rem, r_dvd[WIDTH-1]};
    assign w_trial = w_shift - {1'b0, r_dvs};
    assign w_qbit  = ~w_trial[WIDTH];

    // Control FSM and datapath with registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_sign_q <= 1'b0;
            r_sign_r <= 1'b0;
            r_dvd    <= '0;
            r_dvs    <= '0;
            r_rem    <= '0;
            r_quot   <= '0;
            r_remo   <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_dbz    <= 1'b0;
        end else if (enable) begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_a     <= in1;
                        r_b     <= in2;
                        r_busy  <= 1'b1;
                        r_dbz   <= 1'b0;
                        r_state <= S_PREP;
                    end
                end
                S_PREP: begin
                    r_sign_q <= r_a[WIDTH-1] ^ r_b[WIDTH-1];
                    r_sign_r <= r_a[WIDTH-1];
                    r_dvd    <= w_mag_a;
                    r_dvs    <= w_mag_b;
                    r_rem    <= '0;
                    r_cnt    <= '0;
                    r_state  <= (r_b == '0) ? S_FIX : S_DIVIDE;
                end
                S_DIVIDE: begin
                    r_rem   <= w_qbit ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];
                    r_dvd   <= {r_dvd[WIDTH-2:0], w_qbit};
                    r_cnt   <= r_cnt + 1'b1;
                    if (r_cnt == CW'(WIDTH - 1)) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    if (r_b == '0) begin
                        r_quot <= '1;
                        r_remo <= r_a;
                        r_dbz  <= 1'b1;
                    end else begin
                        r_quot <= r_sign_q ? (~r_dvd + 1'b1) : r_dvd;
                        r_remo <= r_sign_r ? (~r_rem + 1'b1) : r_rem;
                    end
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign quotient    = r_quot;
    assign remainder   = r_remo;
    assign busy        = r_busy;
    assign done        = r_done;
    assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_seq_divider.sv
// Directed-vector bench for seq_divider with hand-computed results.
// Latency is counted in enabled edges after the accepting edge.
// Each operation waits for done under a fixed cycle bound.
module tb_seq_divider;

    logic        clk;
    logic        reset;
    logic        enable;
    logic        start;
    logic [31:0] in1;
    logic [31:0] in2;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        busy;
    logic        done;
    logic        div_by_zero;

    int checks   = 0;
    int failures = 0;

    seq_divider #(.WIDTH(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .start      (start),
        .in1        (in1),
        .in2        (in2),
        .quotient   (quotient),
        .remainder  (remainder),
        .busy       (busy),
        .done       (done),
        .div_by_zero(div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation and wait for done. rp: edge index at which start is
    // re-pulsed with other operands (0 = never). fz: edge index after which
    // enable is dropped for 5 cycles (0 = never).
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int lat,
                          input logic [31:0] eq, input logic [31:0] er, input logic edbz,
                          input string tag, input int rp, input int fz);
        int          n;
        int          tot;
        logic [31:0] q_snap;
        logic [31:0] r_snap;
        in1   = a;
        in2   = b;
        start = 1'b1;
        step();
        start = 1'b0;
        in1   = 32'hDEADBEEF;
        in2   = 32'h00000000;
        n     = 0;
        tot   = 0;
        chk({tag, ".busy_at_start"}, {31'b0, busy}, 32'd1);
        chk({tag, ".dbz_cleared"}, {31'b0, div_by_zero}, 32'd0);
        while (!done && n < 200) begin
            if (rp != 0 && n == rp - 1) begin
                in1   = 32'd100;
                in2   = 32'd3;
                start = 1'b1;
            end
            step();
            start = 1'b0;
            n++;
            tot++;
            if (fz != 0 && n == fz && !done) begin
                enable = 1'b0;
                q_snap = quotient;
                r_snap = remainder;
                repeat (5) begin
                    step();
                    tot++;
                end
                chk({tag, ".frz_busy"}, {31'b0, busy}, 32'd1);
                chk({tag, ".frz_done"}, {31'b0, done}, 32'd0);
                chk({tag, ".frz_quot"}, quotient, q_snap);
                chk({tag, ".frz_rem"}, remainder, r_snap);
                enable = 1'b1;
            end
        end
        chk({tag, ".latency"}, n, lat);
        if (fz != 0) chk({tag, ".total_edges"}, tot, lat + 5);
        chk({tag, ".busy_in_done"}, {31'b0, busy}, 32'd0);
        chk({tag, ".quot"}, quotient, eq);
        chk({tag, ".rem"}, remainder, er);
        chk({tag, ".dbz"}, {31'b0, div_by_zero}, {31'b0, edbz});
    endtask

    initial begin
        int seen_done;
        reset  = 1'b1;
        enable = 1'b1;
        start  = 1'b0;
        in1    = '0;
        in2    = '0;
        step();
        step();
        chk("rst.busy", {31'b0, busy}, 32'd0);
        chk("rst.done", {31'b0, done}, 32'd0);
        chk("rst.quot", quotient, 32'd0);
        chk("rst.rem", remainder, 32'd0);
        chk("rst.dbz", {31'b0, div_by_zero}, 32'd0);
        reset = 1'b0;
        step();

        // Basic signed division
        run_op(-32'sd25, 32'd5, 34, -32'sd5, 32'd0, 1'b0, "t1", 0, 0);

        // Sign matrix, each started in the previous done cycle
        run_op(32'd7, 32'd2, 34, 32'd3, 32'd1, 1'b0, "t2a", 0, 0);
        run_op(-32'sd7, 32'd2, 34, -32'sd3, -32'sd1, 1'b0, "t2b", 0, 0);
        run_op(32'd7, -32'sd2, 34, -32'sd3, 32'd1, 1'b0, "t2c", 0, 0);
        run_op(-32'sd7, -32'sd2, 34, 32'd3, -32'sd1, 1'b0, "t2d", 0, 0);
        run_op(32'd0, 32'd3, 34, 32'd0, 32'd0, 1'b0, "t2e", 0, 0);

        // Zero divisor, then a normal op clears the flag
        run_op(32'd7, 32'd0, 2, 32'hFFFFFFFF, 32'd7, 1'b1, "t3a", 0, 0);
        run_op(32'd40, 32'd4, 34, 32'd10, 32'd0, 1'b0, "t3b", 0, 0);

        // Boundary operands
        run_op(32'h80000000, 32'hFFFFFFFF, 34, 32'h80000000, 32'd0, 1'b0, "t4a", 0, 0);
        run_op(32'h7FFFFFFF, 32'h80000000, 34, 32'd0, 32'h7FFFFFFF, 1'b0, "t4b", 0, 0);
        run_op(32'h80000000, 32'h7FFFFFFF, 34, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, "t4c", 0, 0);

        // Start while busy is ignored; enable freeze mid-DIVIDE
        run_op(32'd49, 32'd7, 34, 32'd7, 32'd0, 1'b0, "t5a", 10, 0);
        run_op(32'd100, 32'd7, 34, 32'd14, 32'd2, 1'b0, "t5b", 0, 15);

        // Done lasts exactly one enabled cycle
        step();
        chk("t5.done_one_cycle", {31'b0, done}, 32'd0);

        // Asynchronous reset mid-operation
        in1   = 32'd35;
        in2   = 32'd5;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (19) step();
        #2;
        reset = 1'b1;
        #1;
        chk("t6.rst_busy", {31'b0, busy}, 32'd0);
        chk("t6.rst_quot", quotient, 32'd0);
        chk("t6.rst_rem", remainder, 32'd0);
        step();
        reset = 1'b0;
        seen_done = 0;
        repeat (40) begin
            step();
            if (done) seen_done = 1;
        end
        chk("t6.no_done_after_rst", seen_done, 0);
        run_op(32'd21, 32'd3, 34, 32'd7, 32'd0, 1'b0, "t6b", 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
